// File: rtl/mmc3_irq_counter.sv
// MMC3-style scanline IRQ counter: decodes CPU writes at $C000-$FFFF, counts filtered
// rising edges of PPU A12 and raises a level IRQ when the reloadable counter reaches zero.
module mmc3_irq_counter #(
    parameter int A12_LOW_CYCLES = 3,
    parameter int ALT_IRQ        = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        mw,
    input  logic        ppu_a12,
    output logic        irq,
    output logic [7:0]  counter
);

    localparam logic [2:0] LOW_MAX = 3'(A12_LOW_CYCLES);

    logic [7:0] r_latch;
    logic [7:0] r_counter;
    logic       r_reload;
    logic       r_enable;
    logic       r_irq;
    logic       r_a12_prev;
    logic [2:0] r_low_cnt;

    logic       w_wr;
    logic       w_wr_c000;
    logic       w_wr_c001;
    logic       w_wr_e000;
    logic       w_wr_e001;
    logic       w_edge;
    logic       w_reload_req;
    logic [7:0] w_cnt_next;
    logic       w_enable_next;
    logic       w_alt_ok;
    logic       w_irq_hit;

    // Value the counter takes on a clocking edge; a same-cycle $C001 write counts as a reload.
    function automatic logic [7:0] f_clock_counter(input logic [7:0] cnt,
                                                   input logic       reload,
                                                   input logic [7:0] latch);
        if (cnt == 8'd0 || reload)
            return latch;
        return cnt - 8'd1;
    endfunction

    always_comb begin
        w_wr          = ce & mw & (addr[15:14] == 2'b11);
        w_wr_c000     = w_wr & ~addr[13] & ~addr[0];
        w_wr_c001     = w_wr & ~addr[13] &  addr[0];
        w_wr_e000     = w_wr &  addr[13] & ~addr[0];
        w_wr_e001     = w_wr &  addr[13] &  addr[0];

        w_edge        = ppu_a12 & ~r_a12_prev & (r_low_cnt == LOW_MAX);
        w_reload_req  = r_reload | w_wr_c001;
        w_cnt_next    = f_clock_counter(r_counter, w_reload_req, r_latch);

        // A same-cycle enable write is already in force for the edge it coincides with.
        w_enable_next = r_enable;
        if (w_wr_e001)
            w_enable_next = 1'b1;
        else if (w_wr_e000)
            w_enable_next = 1'b0;

        w_alt_ok      = (ALT_IRQ == 0) || (r_counter != 8'd0) || w_reload_req;
        w_irq_hit     = w_edge & (w_cnt_next == 8'd0) & w_enable_next & w_alt_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch    <= 8'd0;
            r_counter  <= 8'd0;
            r_reload   <= 1'b0;
            r_enable   <= 1'b0;
            r_irq      <= 1'b0;
            r_a12_prev <= 1'b0;
            r_low_cnt  <= 3'd0;
        end else begin
            r_a12_prev <= ppu_a12;

            if (ppu_a12)
                r_low_cnt <= 3'd0;
            else if (ce && r_low_cnt != LOW_MAX)
                r_low_cnt <= r_low_cnt + 3'd1;

            if (w_wr_c000)
                r_latch <= din;

            if (w_edge) begin
                r_counter <= w_cnt_next;
                r_reload  <= 1'b0;
            end else if (w_wr_c001) begin
                r_counter <= 8'd0;
                r_reload  <= 1'b1;
            end

            r_enable <= w_enable_next;

            // Acknowledge beats a coincident IRQ-setting edge.
            if (w_wr_e000)
                r_irq <= 1'b0;
            else if (w_irq_hit)
                r_irq <= 1'b1;
        end
    end

    assign irq     = r_irq;
    assign counter = r_counter;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Directed bench for mmc3_irq_counter: one DUT with ALT_IRQ=0 and one with ALT_IRQ=1
// share the same stimulus.
module tb_mmc3_irq_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        mw;
    logic        ppu_a12;
    logic        irq_a, irq_b;
    logic [7:0]  counter_a, counter_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmc3_irq_counter #(.A12_LOW_CYCLES(3), .ALT_IRQ(0)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .din(din), .mw(mw),
        .ppu_a12(ppu_a12), .irq(irq_a), .counter(counter_a)
    );

    mmc3_irq_counter #(.A12_LOW_CYCLES(3), .ALT_IRQ(1)) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .din(din), .mw(mw),
        .ppu_a12(ppu_a12), .irq(irq_b), .counter(counter_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; din = d; ce = 1'b1; mw = 1'b1;
        tick();
        ce = 1'b0; mw = 1'b0; addr = 16'h0000;
    endtask

    // A12 low for low_ce enabled cycles, then one rising clock, optionally with a CPU write.
    task automatic a12_rise(input int low_ce, input logic with_wr,
                            input logic [15:0] a, input logic [7:0] d);
        ppu_a12 = 1'b0;
        for (int i = 0; i < low_ce; i++) begin
            ce = 1'b1;
            tick();
        end
        ce = 1'b0;
        tick();
        ppu_a12 = 1'b1;
        if (with_wr) begin
            addr = a; din = d; ce = 1'b1; mw = 1'b1;
        end
        tick();
        ce = 1'b0; mw = 1'b0; addr = 16'h0000;
        tick();
        ppu_a12 = 1'b0;
    endtask

    task automatic rise();
        a12_rise(4, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (counter_a !== 8'd0) begin bad++; $display("FAIL reset_counter: got %0d expected 0", counter_a); end
        total++;
        if (irq_a !== 1'b0) begin bad++; $display("FAIL reset_irq: got %0b expected 0", irq_a); end
    endtask

    task automatic test_countdown();
        logic [7:0] exp_cnt [4];
        exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
        do_reset();
        cpu_write(16'hC000, 8'd3);
        cpu_write(16'hC001, 8'd0);
        cpu_write(16'hE001, 8'd0);
        for (int i = 0; i < 4; i++) begin
            rise();
            total++;
            if (counter_a !== exp_cnt[i]) begin
                bad++; $display("FAIL countdown_cnt%0d: got %0d expected %0d", i, counter_a, exp_cnt[i]);
            end
            if (i == 2) begin
                total++;
                if (irq_a !== 1'b0) begin bad++; $display("FAIL countdown_irq_early: got %0b expected 0", irq_a); end
            end
        end
        total++;
        if (irq_a !== 1'b1) begin bad++; $display("FAIL countdown_irq: got %0b expected 1", irq_a); end
        total++;
        if (irq_b !== 1'b1) begin bad++; $display("FAIL countdown_irq_alt: got %0b expected 1", irq_b); end
    endtask

    task automatic test_ack();
        cpu_write(16'hE000, 8'd0);
        total++;
        if (irq_a !== 1'b0) begin bad++; $display("FAIL ack_irq: got %0b expected 0", irq_a); end
        for (int i = 0; i < 4; i++) rise();
        total++;
        if (counter_a !== 8'd0) begin bad++; $display("FAIL ack_cnt: got %0d expected 0", counter_a); end
        total++;
        if (irq_a !== 1'b0) begin bad++; $display("FAIL ack_disabled_irq: got %0b expected 0", irq_a); end
    endtask

    task automatic test_filter();
        rise();
        chk("filter_reload", counter_a, 8'd3);
        a12_rise(2, 1'b0, 16'h0000, 8'h00);
        chk("filter_short_low", counter_a, 8'd3);
        a12_rise(0, 1'b0, 16'h0000, 8'h00);
        chk("filter_no_low", counter_a, 8'd3);
        a12_rise(3, 1'b0, 16'h0000, 8'h00);
        chk("filter_exact_low", counter_a, 8'd2);
    endtask

    task automatic test_latch_zero();
        do_reset();
        cpu_write(16'hC000, 8'd0);
        cpu_write(16'hC001, 8'd0);
        cpu_write(16'hE001, 8'd0);
        rise();
        chk("zero_first_irq", {7'd0, irq_a}, 8'd1);
        chk("zero_first_irq_alt", {7'd0, irq_b}, 8'd1);
        cpu_write(16'hE000, 8'd0);
        cpu_write(16'hE001, 8'd0);
        rise();
        chk("zero_again_irq", {7'd0, irq_a}, 8'd1);
        chk("zero_again_irq_alt", {7'd0, irq_b}, 8'd0);
        chk("zero_again_cnt", counter_a, 8'd0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        cpu_write(16'hC000, 8'd5);
        cpu_write(16'hE001, 8'd0);
        a12_rise(3, 1'b1, 16'hC001, 8'd0);
        chk("c001_edge_cnt", counter_a, 8'd5);
        rise();
        chk("c001_edge_reload_clr", counter_a, 8'd4);
        for (int i = 0; i < 3; i++) rise();
        chk("pre_ack_cnt", counter_a, 8'd1);
        a12_rise(3, 1'b1, 16'hE000, 8'd0);
        chk("e000_edge_cnt", counter_a, 8'd0);
        chk("e000_edge_irq", {7'd0, irq_a}, 8'd0);
        a12_rise(3, 1'b1, 16'hC000, 8'd9);
        chk("c000_edge_old_latch", counter_a, 8'd5);
        for (int i = 0; i < 4; i++) rise();
        chk("pre_e001_cnt", counter_a, 8'd1);
        a12_rise(3, 1'b1, 16'hE001, 8'd0);
        chk("e001_edge_cnt", counter_a, 8'd0);
        chk("e001_edge_irq", {7'd0, irq_a}, 8'd1);
        rise();
        chk("new_latch_used", counter_a, 8'd9);
    endtask

    task automatic test_mid_reset();
        do_reset();
        cpu_write(16'hC000, 8'd0);
        cpu_write(16'hC001, 8'd0);
        cpu_write(16'hE001, 8'd0);
        rise();
        cpu_write(16'hC000, 8'd7);
        rise();
        chk("midrst_pre_cnt", counter_a, 8'd7);
        chk("midrst_pre_irq", {7'd0, irq_a}, 8'd1);
        do_reset();
        chk("midrst_cnt", counter_a, 8'd0);
        chk("midrst_irq", {7'd0, irq_a}, 8'd0);
        addr = 16'hC000; din = 8'd5; mw = 1'b1; ce = 1'b0;
        tick();
        addr = 16'hE001;
        tick();
        mw = 1'b0; addr = 16'h0000;
        cpu_write(16'h8001, 8'd0);
        cpu_write(16'hC001, 8'd0);
        rise();
        chk("noce_latch_cnt", counter_a, 8'd0);
        chk("noce_enable_irq", {7'd0, irq_a}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ce = 1'b0; mw = 1'b0; addr = 16'h0000; din = 8'h00; ppu_a12 = 1'b0;
        tick();
        test_reset();
        test_countdown();
        test_ack();
        test_filter();
        test_latch_zero();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
